// File: rtl/qkv_feeder_pkg.sv
// Shared vector types, sequence-length type and feeder state enum for the
// Q/K/V feeder and the PE it drives.
package qkv_feeder_pkg;

    localparam int MAX_EMBEDDING_DIM = 4;
    localparam int ELEM_W            = 8;
    localparam int SEQ_LEN_W_DEF     = 16;

    typedef logic [MAX_EMBEDDING_DIM-1:0][ELEM_W-1:0] Q_VECTOR_T;
    typedef logic [MAX_EMBEDDING_DIM-1:0][ELEM_W-1:0] K_VECTOR_T;
    typedef logic [MAX_EMBEDDING_DIM-1:0][ELEM_W-1:0] V_VECTOR_T;

    typedef logic [SEQ_LEN_W_DEF-1:0] SEQ_LEN_T;

    typedef enum logic {
        FEED_IDLE   = 1'b0,
        FEED_STREAM = 1'b1
    } feeder_state_e;

endpackage

// File: rtl/qkv_feeder_sync_fifo.sv
// Type-parameterised synchronous FIFO with valid/ready on both sides.
// Head data is registered storage, so a push is visible one cycle later.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_vld_i,
    output logic push_rdy_o,
    input  T     push_data_i,
    output logic pop_vld_o,
    input  logic pop_rdy_i,
    output T     pop_data_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;

    assign push_rdy_o = (cnt_q != CNT_W'(DEPTH));
    assign pop_vld_o  = (cnt_q != '0);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push       = push_vld_i && push_rdy_o;
    assign pop        = pop_vld_o && pop_rdy_i;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/qkv_feeder.sv
// Feeds one latched Q plus a row of K/V pairs into the PE handshakes.
// Define QKV_FEEDER_B2B_EN to allow the next Q in the cycle that finishes a row.
module qkv_feeder
    import qkv_feeder_pkg::*;
#(
    parameter int KV_DEPTH  = 4,
    parameter int SEQ_LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEQ_LEN_W-1:0] seq_len_in,
    input  logic                 q_vld_in,
    output logic                 q_rdy_out,
    input  Q_VECTOR_T            q_in,
    input  logic                 k_vld_in,
    output logic                 k_rdy_out,
    input  K_VECTOR_T            k_in,
    input  logic                 v_vld_in,
    output logic                 v_rdy_out,
    input  V_VECTOR_T            v_in,
    output logic                 pe_q_vld_out,
    input  logic                 pe_q_rdy_in,
    output Q_VECTOR_T            pe_q_out,
    output logic                 pe_k_vld_out,
    input  logic                 pe_k_rdy_in,
    output K_VECTOR_T            pe_k_out,
    output logic                 pe_v_vld_out,
    input  logic                 pe_v_rdy_in,
    output V_VECTOR_T            pe_v_out,
    output logic [SEQ_LEN_W-1:0] kv_count_out,
    output logic                 row_done_out
);

    feeder_state_e        state_q, state_d;
    logic [SEQ_LEN_W-1:0] len_q, len_d;
    logic [SEQ_LEN_W-1:0] count_q, count_d;
    Q_VECTOR_T            q_q, q_d;
    logic                 done_q, done_d;

    logic                 k_push_rdy, v_push_rdy;
    logic                 k_avail, v_avail;
    logic                 kv_vld;
    logic                 fire;
    logic                 last_pair;
    logic                 q_acc;
    logic [SEQ_LEN_W-1:0] cnt_inc;

    sync_fifo #(.T(K_VECTOR_T), .DEPTH(KV_DEPTH)) u_k_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_vld_i  (k_vld_in),
        .push_rdy_o  (k_push_rdy),
        .push_data_i (k_in),
        .pop_vld_o   (k_avail),
        .pop_rdy_i   (fire),
        .pop_data_o  (pe_k_out)
    );

    sync_fifo #(.T(V_VECTOR_T), .DEPTH(KV_DEPTH)) u_v_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_vld_i  (v_vld_in),
        .push_rdy_o  (v_push_rdy),
        .push_data_i (v_in),
        .pop_vld_o   (v_avail),
        .pop_rdy_i   (fire),
        .pop_data_o  (pe_v_out)
    );

    // Every handshake output is forced low while reset is held.
    assign kv_vld       = !rst && (state_q == FEED_STREAM) && k_avail && v_avail;
    assign fire         = kv_vld && pe_k_rdy_in && pe_v_rdy_in && pe_q_rdy_in;
    assign cnt_inc      = count_q + SEQ_LEN_W'(1);
    assign last_pair    = (cnt_inc == len_q);

`ifdef QKV_FEEDER_B2B_EN
    assign q_rdy_out    = !rst && ((state_q == FEED_IDLE) || (fire && last_pair));
`else
    assign q_rdy_out    = !rst && (state_q == FEED_IDLE);
`endif

    assign q_acc        = q_vld_in && q_rdy_out;
    assign k_rdy_out    = !rst && k_push_rdy;
    assign v_rdy_out    = !rst && v_push_rdy;
    assign pe_q_vld_out = !rst && (state_q == FEED_STREAM);
    assign pe_q_out     = q_q;
    assign pe_k_vld_out = kv_vld;
    assign pe_v_vld_out = kv_vld;
    assign kv_count_out = rst ? '0 : count_q;
    assign row_done_out = !rst && done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FEED_IDLE;
            len_q   <= '0;
            count_q <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    // A Q accept is evaluated after the fire so a back-to-back row overrides
    // the completed row's return to IDLE and restarts the count.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        q_d     = q_q;
        done_d  = 1'b0;
        if (fire) begin
            count_d = cnt_inc;
            if (last_pair) begin
                state_d = FEED_IDLE;
                done_d  = 1'b1;
            end
        end
        if (q_acc) begin
            q_d     = q_in;
            len_d   = seq_len_in;
            count_d = '0;
            if (seq_len_in == '0) begin
                state_d = FEED_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = FEED_STREAM;
            end
        end
    end

endmodule

// File: tb/tb_qkv_feeder.sv
// Randomised self-checking bench for qkv_feeder: a queue-based row model is
// compared against the DUT every cycle, with directed rows pinning key values.
module tb_qkv_feeder;
    import qkv_feeder_pkg::*;

    localparam int KV_DEPTH  = 4;
    localparam int SEQ_LEN_W = 16;

`ifdef QKV_FEEDER_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    SEQ_LEN_T             seq_len_in;
    logic                 q_vld_in, q_rdy_out;
    Q_VECTOR_T            q_in;
    logic                 k_vld_in, k_rdy_out;
    K_VECTOR_T            k_in;
    logic                 v_vld_in, v_rdy_out;
    V_VECTOR_T            v_in;
    logic                 pe_q_vld_out, pe_q_rdy_in;
    Q_VECTOR_T            pe_q_out;
    logic                 pe_k_vld_out, pe_k_rdy_in;
    K_VECTOR_T            pe_k_out;
    logic                 pe_v_vld_out, pe_v_rdy_in;
    V_VECTOR_T            pe_v_out;
    logic [SEQ_LEN_W-1:0] kv_count_out;
    logic                 row_done_out;

    int checks = 0;
    int errors = 0;

    qkv_feeder #(.KV_DEPTH(KV_DEPTH), .SEQ_LEN_W(SEQ_LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .seq_len_in   (seq_len_in),
        .q_vld_in     (q_vld_in),
        .q_rdy_out    (q_rdy_out),
        .q_in         (q_in),
        .k_vld_in     (k_vld_in),
        .k_rdy_out    (k_rdy_out),
        .k_in         (k_in),
        .v_vld_in     (v_vld_in),
        .v_rdy_out    (v_rdy_out),
        .v_in         (v_in),
        .pe_q_vld_out (pe_q_vld_out),
        .pe_q_rdy_in  (pe_q_rdy_in),
        .pe_q_out     (pe_q_out),
        .pe_k_vld_out (pe_k_vld_out),
        .pe_k_rdy_in  (pe_k_rdy_in),
        .pe_k_out     (pe_k_out),
        .pe_v_vld_out (pe_v_vld_out),
        .pe_v_rdy_in  (pe_v_rdy_in),
        .pe_v_out     (pe_v_out),
        .kv_count_out (kv_count_out),
        .row_done_out (row_done_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Row model: K/V queues, the latched Q and length, pairs issued, row-active flag.
    K_VECTOR_T kq[$];
    V_VECTOR_T vq[$];
    Q_VECTOR_T qM = '0;
    int        lenM = 0;
    int        countM = 0;
    bit        active = 1'b0;
    bit        doneM = 1'b0;

    always @(negedge clk) begin
        bit eKV, eFire, eLast, eQr, eKr, eVr, doneNext;
        if (rst) begin
            checkOutput("rst_q_rdy", q_rdy_out, 0);
            checkOutput("rst_k_rdy", k_rdy_out, 0);
            checkOutput("rst_v_rdy", v_rdy_out, 0);
            checkOutput("rst_pe_q_vld", pe_q_vld_out, 0);
            checkOutput("rst_pe_k_vld", pe_k_vld_out, 0);
            checkOutput("rst_pe_v_vld", pe_v_vld_out, 0);
            checkOutput("rst_row_done", row_done_out, 0);
            checkOutput("rst_kv_count", kv_count_out, 0);
            kq.delete();
            vq.delete();
            qM = '0;
            lenM = 0;
            countM = 0;
            active = 1'b0;
            doneM = 1'b0;
        end else begin
            eKV   = active && (kq.size() > 0) && (vq.size() > 0);
            eFire = eKV && pe_q_rdy_in && pe_k_rdy_in && pe_v_rdy_in;
            eLast = eFire && ((countM + 1) == lenM);
            eQr   = !active || (B2B && eLast);
            eKr   = kq.size() < KV_DEPTH;
            eVr   = vq.size() < KV_DEPTH;
            checkOutput("q_rdy", q_rdy_out, eQr);
            checkOutput("k_rdy", k_rdy_out, eKr);
            checkOutput("v_rdy", v_rdy_out, eVr);
            checkOutput("pe_q_vld", pe_q_vld_out, active);
            checkOutput("pe_k_vld", pe_k_vld_out, eKV);
            checkOutput("pe_v_vld", pe_v_vld_out, eKV);
            checkOutput("kv_count", kv_count_out, 64'(countM[SEQ_LEN_W-1:0]));
            checkOutput("row_done", row_done_out, doneM);
            if (active) checkOutput("pe_q_data", pe_q_out, qM);
            if (eKV) begin
                checkOutput("pe_k_data", pe_k_out, kq[0]);
                checkOutput("pe_v_data", pe_v_out, vq[0]);
            end
            doneNext = 1'b0;
            if (eFire) begin
                void'(kq.pop_front());
                void'(vq.pop_front());
                countM++;
                if (countM == lenM) begin
                    active = 1'b0;
                    doneNext = 1'b1;
                end
            end
            if (k_vld_in && eKr) kq.push_back(k_in);
            if (v_vld_in && eVr) vq.push_back(v_in);
            if (q_vld_in && eQr) begin
                qM = q_in;
                lenM = int'(seq_len_in);
                countM = 0;
                if (seq_len_in == '0) doneNext = 1'b1;
                else active = 1'b1;
            end
            doneM = doneNext;
        end
    end

    // Drive one cycle of inputs with fresh random payloads, then step past the edge.
    task automatic applyStimulus(input bit qv, input int sl, input bit kv, input bit vv,
                                 input bit pq, input bit pk, input bit pv);
        q_vld_in    = qv;
        seq_len_in  = SEQ_LEN_T'(sl);
        q_in        = Q_VECTOR_T'($urandom);
        k_vld_in    = kv;
        k_in        = K_VECTOR_T'($urandom);
        v_vld_in    = vv;
        v_in        = V_VECTOR_T'($urandom);
        pe_q_rdy_in = pq;
        pe_k_rdy_in = pk;
        pe_v_rdy_in = pv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("idle_q_rdy", q_rdy_out, 1);

        // Basic row of three pairs, PE always ready.
        applyStimulus(1, 3, 1, 1, 1, 1, 1);
        checkOutput("basic_q_vld", pe_q_vld_out, 1);
        applyStimulus(0, 0, 1, 1, 1, 1, 1);
        checkOutput("basic_cnt1", kv_count_out, 1);
        applyStimulus(0, 0, 1, 1, 1, 1, 1);
        checkOutput("basic_cnt2", kv_count_out, 2);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("basic_cnt3", kv_count_out, 3);
        checkOutput("basic_done", row_done_out, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("basic_done_pulse", row_done_out, 0);
        checkOutput("basic_cnt_hold", kv_count_out, 3);

        // Backpressure on V for two cycles.
        applyStimulus(1, 2, 1, 1, 1, 1, 1);
        checkOutput("bp_kv_vld", pe_k_vld_out, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkOutput("bp_stall_cnt", kv_count_out, 0);
        applyStimulus(0, 0, 1, 1, 1, 1, 1);
        checkOutput("bp_resume_cnt", kv_count_out, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("bp_cnt2", kv_count_out, 2);
        checkOutput("bp_done", row_done_out, 1);

        // Zero-length row.
        applyStimulus(1, 0, 0, 0, 1, 1, 1);
        checkOutput("zero_done", row_done_out, 1);
        checkOutput("zero_q_vld", pe_q_vld_out, 0);
        checkOutput("zero_q_rdy", q_rdy_out, 1);

        // K-only fill to full, then a single V releases exactly one pair.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 0, 1, 1, 1);
            if (i == 3) checkOutput("full_k_rdy", k_rdy_out, 0);
        end
        applyStimulus(1, 1, 0, 0, 1, 1, 1);
        checkOutput("imb_k_vld", pe_k_vld_out, 0);
        applyStimulus(0, 0, 0, 1, 1, 1, 1);
        checkOutput("imb_k_vld_v", pe_k_vld_out, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("imb_done", row_done_out, 1);
        checkOutput("imb_cnt", kv_count_out, 1);

        // Back-to-back rows of two with Q held valid.
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 1, 1, 1);
        applyStimulus(1, 2, 0, 0, 1, 1, 1);
        applyStimulus(1, 2, 0, 0, 1, 1, 1);
        applyStimulus(1, 2, 0, 0, 1, 1, 1);
        checkOutput("b2b_done", row_done_out, 1);
        checkOutput("b2b_q_vld", pe_q_vld_out, B2B);
        checkOutput("b2b_cnt", kv_count_out, B2B ? 0 : 2);
        applyStimulus(1, 2, 0, 0, 1, 1, 1);
        checkOutput("b2b_q_vld2", pe_q_vld_out, 1);
        checkOutput("b2b_cnt2", kv_count_out, B2B ? 1 : 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 1, 1);

        // Reset after one of three fires.
        applyStimulus(1, 3, 1, 1, 1, 1, 1);
        applyStimulus(0, 0, 1, 1, 1, 1, 1);
        checkOutput("mid_cnt1", kv_count_out, 1);
        rst = 1'b1;
        applyStimulus(0, 0, 1, 1, 1, 1, 1);
        checkOutput("mid_rst_q_vld", pe_q_vld_out, 0);
        checkOutput("mid_rst_k_vld", pe_k_vld_out, 0);
        checkOutput("mid_rst_cnt", kv_count_out, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("post_rst_q_vld", pe_q_vld_out, 0);
        checkOutput("post_rst_done", row_done_out, 0);
        applyStimulus(1, 1, 1, 1, 1, 1, 1);
        checkOutput("post_rst_kv_vld", pe_k_vld_out, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("post_rst_cnt", kv_count_out, 1);
        checkOutput("post_rst_row_done", row_done_out, 1);

        // Random traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 4),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
